// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64I control sequencer:
// state encoding, major opcodes and datapath select encodings.
package riscv_ctrl_pkg;

    // Sequencer states; the numeric value is what the debug state port shows.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_ERROR  = 4'd11
    } state_t;

    // Major opcodes, instruction bits [6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation class handed to the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // ALU operand B source
    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    // States that hold a request on the shared memory port
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory request and flags the
// cycle on which the last permitted wait is spent without completion.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_mem,
    input  logic mem_ready,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] wait_cnt;
    logic          stalled;

    assign stalled = in_mem && !mem_ready;
    assign timeout = stalled && (wait_cnt == CW'(MEM_TIMEOUT - 1));

    // Count stalled cycles; completion, timeout or leaving the state clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!stalled || timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV64I datapath. Moore outputs per state,
// plus fetch-completion strobes that depend on mem_ready in S_FETCH.
//
// Memory handshake: mem_read / mem_write are requests held high for every
// cycle of a memory state; the transfer completes in the cycle mem_ready=1,
// and the FSM leaves the state at the following edge. A request stalled for
// MEM_TIMEOUT cycles sends the FSM to S_ERROR.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               pc_source,
    output logic               error,
    output logic [COUNT_W-1:0] retired,
    output logic [3:0]         state
);

    state_t             cur_state;
    state_t             next_state;
    logic               timeout;
    logic               retire;
    logic [COUNT_W-1:0] retired_q;

    assign state   = cur_state;
    assign retired = retired_q;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .in_mem   (is_mem_state(cur_state)),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + COUNT_W'(1);
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state    = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        pc_source     = 1'b0;
        error         = 1'b0;
        retire        = 1'b0;

        case (cur_state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_ERROR;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH1;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXEC_R;
                    OP_ITYPE:          next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    default:           next_state = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_LOAD) begin
                    next_state = S_MEMRD;
                end else if (opcode == OP_STORE) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_ERROR;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timeout) begin
                    next_state = S_ERROR;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end else if (timeout) begin
                    next_state = S_ERROR;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_RTYPE;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ITYPE;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                next_state    = S_FETCH;
                retire        = 1'b1;
            end
            default: begin
                // S_ERROR and unused encodings park here until reset
                error      = 1'b1;
                next_state = S_ERROR;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-written corner
// sequences (illegal opcode, memory timeout, async reset) and randomized
// instruction streams checked against a trace-level reference model.
module tb_multicycle_control;
    import riscv_ctrl_pkg::*;

    localparam int CW  = 4;   // small counter so wrap-around is exercised
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, ir_write, i_or_d, mem_read;
    logic          mem_write, mem_to_reg, reg_write, alu_src_a, pc_source, error;
    logic [1:0]    alu_src_b, alu_op;
    logic [CW-1:0] retired;
    logic [3:0]    state;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.MEM_TIMEOUT(TMO), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .error(error), .retired(retired), .state(state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       error;
    } ctrl_t;

    typedef struct {
        logic [6:0] opc;
        logic       rdy;
        state_t     st;
        int         ret;
    } vec_t;

    typedef struct {
        state_t st;
        logic   rdy;
    } step_t;

    vec_t  tbl[20];
    step_t steps[$];

    function automatic ctrl_t act_ctrl();
        ctrl_t c;
        c = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, error};
        return c;
    endfunction

    // Required control word for a state, straight from the per-state rules
    function automatic ctrl_t exp_ctrl(input state_t st, input logic rdy);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01;
                            c.ir_write = rdy; c.pc_write = rdy; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1; c.i_or_d = 1; end
            S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MEMWR:  begin c.mem_write = 1; c.i_or_d = 1; end
            S_EXEC_R: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_EXEC_I: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            S_ALUWB:  c.reg_write = 1;
            S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01;
                            c.pc_write_cond = 1; c.pc_source = 1; end
            S_ERROR:  c.error = 1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check outputs 1ns later
    task automatic apply_check(input logic [6:0] opc, input logic rdy, input state_t st,
                               input int ret, input string tag);
        @(negedge clk);
        opcode    = opc;
        mem_ready = rdy;
        #1;
        chk({tag, " state"},   32'(state),      32'(st));
        chk({tag, " ctrl"},    32'(act_ctrl()), 32'(exp_ctrl(st, rdy)));
        chk({tag, " retired"}, 32'(retired),    32'(ret % (1 << CW)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset state",   32'(state),      32'(S_IDLE));
        chk("reset ctrl",    32'(act_ctrl()), 32'(0));
        chk("reset retired", 32'(retired),    32'(0));
        reset = 1'b1;
        #1;
        chk("release state", 32'(state), 32'(S_IDLE));
    endtask

    // Reference model: expected per-cycle trace of one instruction
    task automatic build(input logic [6:0] opc, input int wf, input int wm);
        steps.delete();
        for (int k = 0; k < wf; k++) steps.push_back('{S_FETCH, 1'b0});
        steps.push_back('{S_FETCH, 1'b1});
        steps.push_back('{S_DECODE, 1'b1});
        if (opc == OP_LOAD || opc == OP_STORE) begin
            steps.push_back('{S_MEMADR, 1'b1});
            for (int k = 0; k < wm; k++)
                steps.push_back('{(opc == OP_LOAD) ? S_MEMRD : S_MEMWR, 1'b0});
            steps.push_back('{(opc == OP_LOAD) ? S_MEMRD : S_MEMWR, 1'b1});
            if (opc == OP_LOAD) steps.push_back('{S_MEMWB, 1'b1});
        end else if (opc == OP_BRANCH) begin
            steps.push_back('{S_BRANCH, 1'b1});
        end else begin
            steps.push_back('{(opc == OP_RTYPE) ? S_EXEC_R : S_EXEC_I, 1'b1});
            steps.push_back('{S_ALUWB, 1'b1});
        end
    endtask

    initial begin
        int n_done;
        logic [6:0] opc;

        reset     = 1'b0;
        opcode    = '0;
        mem_ready = 1'b0;

        // R-type, load with two read waits, store, branch
        tbl[0]  = '{OP_RTYPE,  1'b1, S_FETCH,  0};
        tbl[1]  = '{OP_RTYPE,  1'b1, S_DECODE, 0};
        tbl[2]  = '{OP_RTYPE,  1'b1, S_EXEC_R, 0};
        tbl[3]  = '{OP_RTYPE,  1'b1, S_ALUWB,  0};
        tbl[4]  = '{OP_LOAD,   1'b1, S_FETCH,  1};
        tbl[5]  = '{OP_LOAD,   1'b1, S_DECODE, 1};
        tbl[6]  = '{OP_LOAD,   1'b1, S_MEMADR, 1};
        tbl[7]  = '{OP_LOAD,   1'b0, S_MEMRD,  1};
        tbl[8]  = '{OP_LOAD,   1'b0, S_MEMRD,  1};
        tbl[9]  = '{OP_LOAD,   1'b1, S_MEMRD,  1};
        tbl[10] = '{OP_LOAD,   1'b1, S_MEMWB,  1};
        tbl[11] = '{OP_STORE,  1'b1, S_FETCH,  2};
        tbl[12] = '{OP_STORE,  1'b1, S_DECODE, 2};
        tbl[13] = '{OP_STORE,  1'b1, S_MEMADR, 2};
        tbl[14] = '{OP_STORE,  1'b1, S_MEMWR,  2};
        tbl[15] = '{OP_BRANCH, 1'b1, S_FETCH,  3};
        tbl[16] = '{OP_BRANCH, 1'b1, S_DECODE, 3};
        tbl[17] = '{OP_BRANCH, 1'b1, S_BRANCH, 3};
        tbl[18] = '{OP_ITYPE,  1'b1, S_FETCH,  4};
        tbl[19] = '{OP_ITYPE,  1'b1, S_DECODE, 4};

        do_reset();
        for (int i = 0; i < 20; i++)
            apply_check(tbl[i].opc, tbl[i].rdy, tbl[i].st, tbl[i].ret, $sformatf("vec%0d", i));
        apply_check(OP_ITYPE, 1'b1, S_EXEC_I, 4, "itype exec");
        apply_check(OP_ITYPE, 1'b1, S_ALUWB,  4, "itype wb");
        apply_check(OP_ITYPE, 1'b1, S_FETCH,  5, "itype done");

        // Illegal opcode: sticky error, retired frozen
        apply_check(7'b1111111, 1'b1, S_DECODE, 5, "ill decode");
        for (int i = 0; i < 20; i++)
            apply_check(7'b1111111, 1'($urandom_range(0, 1)), S_ERROR, 5, "ill hold");
        do_reset();

        // Fetch timeout: 16 stalled request cycles, then error
        for (int i = 0; i < TMO; i++) apply_check(OP_RTYPE, 1'b0, S_FETCH, 0, "tmo wait");
        apply_check(OP_RTYPE, 1'b0, S_ERROR, 0, "tmo err");
        do_reset();

        // Ready on the last permitted cycle completes normally
        for (int i = 0; i < TMO - 1; i++) apply_check(OP_RTYPE, 1'b0, S_FETCH, 0, "edge wait");
        apply_check(OP_RTYPE, 1'b1, S_FETCH,  0, "edge done");
        apply_check(OP_RTYPE, 1'b1, S_DECODE, 0, "edge decode");
        do_reset();

        // Async reset in the middle of a stalled store
        apply_check(OP_RTYPE, 1'b1, S_FETCH,  0, "ar fetch");
        apply_check(OP_RTYPE, 1'b1, S_DECODE, 0, "ar decode");
        apply_check(OP_RTYPE, 1'b1, S_EXEC_R, 0, "ar exec");
        apply_check(OP_RTYPE, 1'b1, S_ALUWB,  0, "ar wb");
        apply_check(OP_STORE, 1'b1, S_FETCH,  1, "ar sfetch");
        apply_check(OP_STORE, 1'b1, S_DECODE, 1, "ar sdecode");
        apply_check(OP_STORE, 1'b1, S_MEMADR, 1, "ar memadr");
        apply_check(OP_STORE, 1'b0, S_MEMWR,  1, "ar memwr");
        #2;
        reset = 1'b0;
        #1;
        chk("ar mem_write", 32'(mem_write), 32'(0));
        chk("ar state",     32'(state),     32'(S_IDLE));
        chk("ar retired",   32'(retired),   32'(0));
        do_reset();

        // Randomized instruction stream against the trace model
        n_done = 0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       opc = OP_LOAD;
                1:       opc = OP_STORE;
                2:       opc = OP_RTYPE;
                3:       opc = OP_ITYPE;
                default: opc = OP_BRANCH;
            endcase
            build(opc, $urandom_range(0, 3), $urandom_range(0, 3));
            foreach (steps[k])
                apply_check(opc, steps[k].rdy, steps[k].st, n_done, $sformatf("rnd%0d", n));
            n_done++;
        end
        apply_check(OP_RTYPE, 1'b0, S_FETCH, n_done, "rnd end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer that drives the RV64I datapath as a multi-cycle machine sharing one memory port for instruction and data. It is a Moore FSM with Mealy handshake strobes, plus a memory-wait timeout and a retired-instruction counter. It sits beside the datapath and replaces the single-cycle opcode decoder as the source of every mux select and write enable. It decodes opcode bits [6:0] from the instruction register.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles a memory state may wait with mem_ready low before entering S_ERROR (must be >= 1)
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
opcode  in  7  instruction[6:0] from instruction register, valid from S_DECODE onward
mem_ready  in  1  shared memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (datapath does the AND)
ir_write  out  1  load instruction register from memory read data
i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result register
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  register write data: 0 = ALU result register, 1 = memory data register
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = rs1
alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate, 11 = immediate<<1
alu_op  out  2  00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode
pc_source  out  1  0 = ALU result (PC+4), 1 = ALU result register (branch target)
error  out  1  sticky fault flag
retired  out  COUNT_W  count of completed instructions, wraps modulo 2^COUNT_W
state  out  4  current state encoding, for debug

Behaviour:
- Reset (reset=0, async): state=S_IDLE, retired=0, error=0, wait_cnt=0. All strobes and selects are 0 while in S_IDLE.
- S_IDLE -> S_FETCH unconditionally on the next edge after reset deasserts.
- S_FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready=1, ir_write=1, pc_write=1 and pc_source=0 in the same cycle, then -> S_DECODE.
  - Else stay in S_FETCH.
- S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; the branch target is precomputed. Next state by opcode:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXEC_R
  - 0010011 -> S_EXEC_I
  - 1100011 -> S_BRANCH
  - anything else -> S_ERROR
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is S_MEMRD for a load, S_MEMWR for a store. Opcode is held stable by the instruction register.
- S_MEMRD: mem_read=1, i_or_d=1. Advances to S_MEMWB on mem_ready, else waits.
- S_MEMWB: reg_write=1, mem_to_reg=1 -> S_FETCH.
- S_MEMWR: mem_write=1, i_or_d=1. Advances to S_FETCH on mem_ready, else waits.
- S_EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> S_ALUWB.
- S_EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 -> S_ALUWB.
- S_ALUWB: reg_write=1, mem_to_reg=0 -> S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1 -> S_FETCH.
- S_ERROR: all strobes 0, error=1. Held until reset.
- Latency with zero wait states: load 5 cycles, store/R/I 4 cycles, branch 3 cycles.
- Each memory wait cycle (S_FETCH, S_MEMRD, S_MEMWR with mem_ready=0) adds exactly one cycle.
- Timeout:
  - wait_cnt increments each cycle a memory state sees mem_ready=0.
  - wait_cnt clears on mem_ready=1 or on leaving the state.
  - When wait_cnt == MEM_TIMEOUT-1 and mem_ready=0 -> S_ERROR next edge, with no strobe that cycle besides the request.
  - mem_ready=1 on the final permitted cycle completes normally.
- retired increments by 1 on every transition into S_FETCH from S_MEMWB, S_MEMWR, S_ALUWB or S_BRANCH. It does not increment from S_IDLE, and wraps to 0 at all-ones.
- Reset asserted mid-instruction aborts immediately: no partial strobes after the reset edge, and retired clears.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enumeration (4-bit localparams S_IDLE..S_ERROR)
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH
  - ALUOp and alu_src_b encodings
- One sub-module, mem_wait_timer: wait_cnt plus the timeout compare.
- The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset then R-type (opcode 0110011), mem_ready tied 1 -> states IDLE,FETCH,DECODE,EXEC_R,ALUWB,FETCH; reg_write=1 only in ALUWB; retired=1.
- Load (0000011) with 2 wait cycles in MEMRD -> mem_read=1, i_or_d=1 for 3 cycles; MEMWB asserts reg_write and mem_to_reg; total 7 cycles; retired+1.
- Store then branch (0100011, 1100011), ready=1 -> mem_write pulses exactly 1 cycle; pc_write_cond=1 with pc_source=1 in BRANCH; retired +2 after 7 cycles.
- Illegal opcode 1111111 in DECODE -> S_ERROR, error=1 sticky, all strobes 0 for 20 cycles, retired frozen; reset=0 clears to IDLE.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 -> S_ERROR after exactly 16 request cycles; variant with ready on cycle 16 completes fetch normally.
- Assert reset=0 asynchronously mid-S_MEMWR -> mem_write drops without waiting for a clock edge; state=S_IDLE, retired=0.
